// File: rtl/run_if.sv
// run_if: command/status bundle between a run controller and its user.
// master drives start/abort/halt; slave reports DUT reset and run outcome.
interface run_if #(
  parameter int PC_W   = 32,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic              halt_valid;
  logic [PC_W-1:0]   halt_pc;
  logic [NUM_CH-1:0] dut_rst_n;
  logic              running;
  logic              done;
  logic              halted;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, abort, halt_valid, halt_pc,
    input  dut_rst_n, running, done, halted, timeout, cycle_count
  );

  modport slave (
    input  start, abort, halt_valid, halt_pc,
    output dut_rst_n, running, done, halted, timeout, cycle_count
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: staggered multi-channel DUT reset, then a bounded run ending on
// halt-PC match or cycle budget. Ports: CLK, RST (sync, active-low), bus (run_if.slave).
module run_ctrl #(
  parameter int              RST_CYCLES = 2,
  parameter int              NUM_CH     = 2,
  parameter int              STAGGER    = 1,
  parameter int              RUN_CYCLES = 20,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] HALT_ADDR  = PC_W'(32'h0000_0040),
  parameter int              CNT_W      = 16,
  parameter int              AUTO_START = 1
) (
  input  logic CLK,
  input  logic RST,
  run_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int LAST = RST_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int SW   = $clog2(LAST + 1) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RUN_CYCLES - 1);

  state_t            st, nx;
  logic [SW-1:0]     seq_q, seq_d, seq_nx;
  logic [31:0]       seq_ext;
  logic [NUM_CH-1:0] dut_q, dut_d;
  logic [CNT_W-1:0]  cc_q, cc_d;
  logic              run_q, done_q, hlt_q, to_q;
  logic              hlt_d, to_d;
  logic              go, halt_hit, to_hit, abort_hit;

  // seq counts edges since ASSERT entry; seq_nx is its value after this edge
  assign seq_nx    = seq_q + SW'(1);
  assign seq_ext   = 32'(seq_nx);
  assign go        = bus.start || (AUTO_START != 0);
  assign halt_hit  = bus.halt_valid && (bus.halt_pc == HALT_ADDR);
  assign to_hit    = (RUN_CYCLES != 0) && (cc_q == TO_LAST);
  assign abort_hit = bus.abort && (st != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      st     <= S_IDLE;
      seq_q  <= '0;
      dut_q  <= '0;
      cc_q   <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      hlt_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      st     <= nx;
      seq_q  <= seq_d;
      dut_q  <= dut_d;
      cc_q   <= cc_d;
      run_q  <= (nx == S_RUN);
      done_q <= (nx == S_DONE);
      hlt_q  <= hlt_d;
      to_q   <= to_d;
    end
  end

  always_comb begin
    nx = st;
    if (abort_hit) begin
      nx = S_IDLE;
    end else begin
      unique case (st)
        S_IDLE:
          if (go) nx = S_ASSERT;
        S_ASSERT, S_RELEASE:
          if (seq_ext >= 32'(LAST)) nx = S_RUN;
          else if (seq_ext >= 32'(RST_CYCLES)) nx = S_RELEASE;
        S_RUN:
          if (halt_hit || to_hit) nx = S_DONE;
        S_DONE:
          if (bus.start) nx = S_ASSERT;
        default:
          nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    seq_d = seq_q;
    dut_d = dut_q;
    cc_d  = cc_q;
    hlt_d = hlt_q;
    to_d  = to_q;
    if (abort_hit) begin
      dut_d = '0;
      hlt_d = 1'b0;
      to_d  = 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
          dut_d = '0;
          if (go) begin
            seq_d = '0;
            cc_d  = '0;
            hlt_d = 1'b0;
            to_d  = 1'b0;
          end
        end
        S_ASSERT, S_RELEASE: begin
          seq_d = seq_nx;
          for (int k = 0; k < NUM_CH; k++)
            if (seq_ext >= 32'(RST_CYCLES + k * STAGGER))
              dut_d[k] = 1'b1;
        end
        S_RUN: begin
          if (cc_q != '1) cc_d = cc_q + CNT_W'(1);
          // halt outranks a coincident timeout
          if (halt_hit) hlt_d = 1'b1;
          else if (to_hit) to_d = 1'b1;
        end
        S_DONE: begin
          if (bus.start) begin
            dut_d = '0;
            seq_d = '0;
            cc_d  = '0;
            hlt_d = 1'b0;
            to_d  = 1'b0;
          end
        end
        default: dut_d = '0;
      endcase
    end
  end

  assign bus.dut_rst_n   = dut_q;
  assign bus.running     = run_q;
  assign bus.done        = done_q;
  assign bus.halted      = hlt_q;
  assign bus.timeout     = to_q;
  assign bus.cycle_count = cc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized directed bench for run_ctrl against a timing model.
// Two instances: default parameters, and 4 channels / no stagger / no budget.
module tb_run_ctrl;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int S  = 1;
  localparam int T  = 20;
  localparam int ER = R + (C - 1) * S;
  localparam logic [31:0] HALT = 32'h40;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  run_if #(.PC_W(32), .NUM_CH(2), .CNT_W(16)) b1 ();
  run_if #(.PC_W(32), .NUM_CH(4), .CNT_W(4))  b2 ();

  run_ctrl #(
    .RST_CYCLES(R), .NUM_CH(C), .STAGGER(S), .RUN_CYCLES(T),
    .PC_W(32), .HALT_ADDR(HALT), .CNT_W(16), .AUTO_START(1)
  ) u1 (.CLK(CLK), .RST(RST), .bus(b1.slave));

  run_ctrl #(
    .RST_CYCLES(1), .NUM_CH(4), .STAGGER(0), .RUN_CYCLES(0),
    .PC_W(32), .HALT_ADDR(HALT), .CNT_W(4), .AUTO_START(0)
  ) u2 (.CLK(CLK), .RST(RST), .bus(b2.slave));

  function automatic logic [63:0] obs1();
    return 64'({b1.dut_rst_n, b1.running, b1.done,
                b1.halted, b1.timeout, b1.cycle_count});
  endfunction

  function automatic logic [63:0] obs2();
    return 64'({b2.dut_rst_n, b2.running, b2.done,
                b2.halted, b2.timeout, b2.cycle_count});
  endfunction

  function automatic logic [63:0] pk1(logic [1:0] d, logic r, logic dn,
                                      logic h, logic t, int cc);
    return 64'({d, r, dn, h, t, 16'(cc)});
  endfunction

  function automatic logic [63:0] pk2(logic [3:0] d, logic r, logic dn,
                                      logic h, logic t, int cc);
    return 64'({d, r, dn, h, t, 4'(cc)});
  endfunction

  function automatic int run_len(int h);
    return (h > 0 && h <= T) ? h : T;
  endfunction

  // Expected dut1 outputs n edges after E0, halt seen on RUN cycle h (0 = none)
  function automatic logic [63:0] exp1(int n, int h);
    int         e;
    int         m;
    logic [1:0] d;
    logic       hl;
    e = run_len(h);
    m = n - ER;
    if (n < ER) begin
      for (int k = 0; k < C; k++) d[k] = (n >= R + k * S);
      return pk1(d, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    if (m < e) return pk1(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, m);
    hl = (h > 0 && h <= T);
    return pk1(2'b11, 1'b0, 1'b1, hl, !hl, e);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives edges E0..last of one run on dut1; next edge must be E0
  task automatic do_run(input int h, input bit use_start, input int nlast);
    int e;
    int last;
    logic [31:0] pc;
    e = run_len(h);
    last = (nlast < 0) ? ER + e + 2 : nlast;
    for (int n = 0; n <= last; n++) begin
      if (n == 0) b1.start = use_start;
      else if (n <= ER + e) b1.start = 1'($urandom_range(0, 1));
      else b1.start = 1'b0;
      if (h > 0 && n == ER + h) begin
        b1.halt_valid = 1'b1;
        b1.halt_pc = HALT;
      end else if ($urandom_range(0, 1) == 1) begin
        pc = $urandom;
        if (pc == HALT) pc = HALT + 32'd4;
        b1.halt_valid = 1'b1;
        b1.halt_pc = pc;
      end else begin
        b1.halt_valid = 1'b0;
        b1.halt_pc = HALT;
      end
      tick();
      chk($sformatf("run h=%0d n=%0d", h, n), obs1(), exp1(n, h));
    end
    b1.start = 1'b0;
    b1.halt_valid = 1'b0;
  endtask

  initial begin
    b1.start = 0; b1.abort = 0; b1.halt_valid = 0; b1.halt_pc = 0;
    b2.start = 0; b2.abort = 0; b2.halt_valid = 0; b2.halt_pc = 0;

    RST = 1'b0;
    tick();
    chk("reset1", obs1(), 64'd0);
    chk("reset2", obs2(), 64'd0);

    RST = 1'b1;
    do_run(0, 1'b0, -1);
    do_run(5, 1'b1, -1);
    do_run(20, 1'b1, -1);
    repeat (6) do_run(int'($urandom_range(1, 25)), 1'b1, -1);

    do_run(0, 1'b1, ER + 7);
    b1.abort = 1'b1;
    b1.start = 1'b1;
    b1.halt_valid = 1'b1;
    b1.halt_pc = HALT;
    tick();
    chk("abort", obs1(), pk1(2'b00, 0, 0, 0, 0, 7));
    b1.abort = 1'b0;
    b1.start = 1'b0;
    b1.halt_valid = 1'b0;
    do_run(0, 1'b0, -1);

    do_run(0, 1'b1, ER + 4);
    RST = 1'b0;
    tick();
    chk("midrun_rst", obs1(), 64'd0);
    RST = 1'b1;
    do_run(0, 1'b0, -1);

    chk("idle2", obs2(), 64'd0);
    b2.start = 1'b1;
    tick();
    chk("e0_2", obs2(), pk2(4'h0, 0, 0, 0, 0, 0));
    b2.start = 1'b0;
    tick();
    chk("e1_2", obs2(), pk2(4'hf, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 20; i++) begin
      b2.halt_valid = 1'($urandom_range(0, 1));
      b2.halt_pc = HALT + 32'd8;
      tick();
      chk($sformatf("sat2 i=%0d", i), obs2(),
          pk2(4'hf, 1, 0, 0, 0, (i > 15) ? 15 : i));
    end
    b2.halt_valid = 1'b1;
    b2.halt_pc = HALT;
    tick();
    chk("halt2", obs2(), pk2(4'hf, 0, 1, 1, 0, 15));
    b2.halt_valid = 1'b0;
    tick();
    chk("hold2", obs2(), pk2(4'hf, 0, 1, 1, 0, 15));
    b2.start = 1'b1;
    tick();
    chk("restart2", obs2(), pk2(4'h0, 0, 0, 0, 0, 0));
    b2.start = 1'b0;
    tick();
    chk("rerelease2", obs2(), pk2(4'hf, 1, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run controller for processor-level simulation and FPGA bring-up of the multi-cycle MIPS core. It sequences a multi-channel DUT reset with a configurable length and stagger, then counts run cycles. A run ends on a halt-PC match or a cycle-budget timeout, and the block reports the outcome. It sits between the board/bench clock and reset and the `Top` instance(s), and replaces fixed reset pulses and fixed run lengths with a parametrised, restartable sequence.

## Interface
Parameters:
- `RST_CYCLES`, default 2: cycles all DUT resets are held low after a run starts; must be ≥1.
- `NUM_CH`, default 2: number of independent DUT reset channels.
- `STAGGER`, default 1: cycles between successive channel releases; 0 releases all channels on the same edge.
- `RUN_CYCLES`, default 20: cycle budget; 0 disables the timeout.
- `PC_W`, default 32: width of the halt-PC input.
- `HALT_ADDR`, default 32'h0000_0040: PC value that signals a halt.
- `CNT_W`, default 16: width of the cycle counter.
- `AUTO_START`, default 1: when 1, the block starts a run without `start` on the first edge after `RST` is released.

Ports:
- `CLK` input, 1 bit: single clock; all logic is on the rising edge.
- `RST` input, 1 bit: synchronous reset, active-low.
- `start` input, 1 bit: level-sampled run request.
- `abort` input, 1 bit: forces a return to IDLE.
- `halt_valid` input, 1 bit: `halt_pc` is valid this cycle.
- `halt_pc` input, `PC_W` bits: current DUT PC.
- `dut_rst_n` output, `NUM_CH` bits: per-channel DUT reset, active-low.
- `running` output, 1 bit: state is RUN.
- `done` output, 1 bit: state is DONE.
- `halted` output, 1 bit: the last run ended on a PC match.
- `timeout` output, 1 bit: the last run ended on the cycle budget.
- `cycle_count` output, `CNT_W` bits: number of RUN cycles in the current or last run.

## Operation
- States: IDLE, ASSERT, RELEASE, RUN, DONE. All outputs are registered.
- Reset: `RST`=0 at a rising edge puts the block in IDLE. Reset values: `dut_rst_n`=0 on all channels, `running`=0, `done`=0, `halted`=0, `timeout`=0, `cycle_count`=0.
- IDLE:
  - `dut_rst_n` is held at all zeros.
  - If `start`=1 or `AUTO_START`=1, the next state is ASSERT. The internal counter and `cycle_count` are cleared.
- ASSERT:
  - All channels are held low.
  - After `RST_CYCLES` edges in ASSERT, channel 0 is released. The next state is RELEASE, or RUN if `NUM_CH`=1 or `STAGGER`=0 (in that case all channels are released on that edge).
- RELEASE:
  - Channel k rises `RST_CYCLES + k*STAGGER` edges after ASSERT entry.
  - The next state is RUN on the edge that releases channel `NUM_CH`-1.
  - Released channels stay at 1 until IDLE or a restart.
- RUN:
  - `cycle_count` increments on every edge in RUN, including the edge that terminates the run. It saturates at all-ones when the timeout is disabled.
  - A halt is detected when `halt_valid`=1 and `halt_pc`=`HALT_ADDR`. The next state is DONE and `halted` is set to 1.
  - A timeout is detected when `RUN_CYCLES`≠0 and `cycle_count`=`RUN_CYCLES`-1. The next state is DONE and `timeout` is set to 1.
  - If a halt and a timeout occur on the same edge, halt wins: `halted`=1, `timeout`=0.
- DONE:
  - `dut_rst_n` stays all ones, so DUT state is preserved for inspection.
  - `halted`, `timeout` and `cycle_count` hold their values.
  - `start`=1 goes to ASSERT, clears the flags and `cycle_count`, and drives all channels low on that edge.
  - `AUTO_START` does not retrigger from DONE.
- `abort`=1 in any state other than IDLE:
  - The next state is IDLE.
  - All outputs take their reset values, except that `cycle_count` holds.
  - `abort` has priority over halt, timeout and `start`.
- `start` is ignored in ASSERT, RELEASE and RUN.

## Timing
- Edge E0 is the first edge that samples `RST`=1 (`AUTO_START`=1), or the edge that samples `start`=1 in IDLE. At E0 the state becomes ASSERT.
- Channel k rises at E0+`RST_CYCLES`+k·`STAGGER`.
- `running` rises at E0+`RST_CYCLES`+(`NUM_CH`-1)·`STAGGER`.
- A timeout sets `done` `RUN_CYCLES` edges after RUN entry, with `cycle_count`=`RUN_CYCLES`.
- A halt sets `done` one edge after the qualifying `halt_valid` cycle.
- `RST`=0 mid-run drives every channel low on the same edge. There is no drain and no partial sequence.

## Test plan
- Default parameters, `RST` low for 1 cycle, then held high → ASSERT at E0; `dut_rst_n[0]` rises at E2; `dut_rst_n[1]` rises at E3 together with `running`; `done`=1 and `timeout`=1 at E23; `cycle_count`=20; `halted`=0.
- `halt_valid`=1 with `halt_pc`=0x40 on the 5th RUN cycle → `done` on the next edge; `halted`=1, `timeout`=0, `cycle_count`=5; `dut_rst_n`=2'b11 is held.
- Halt and timeout coincide (`halt_pc`=0x40 on RUN cycle 20) → `halted`=1, `timeout`=0.
- `abort` on RUN cycle 7 → IDLE next edge; `dut_rst_n`=0, `running`=0, `cycle_count`=7; with `AUTO_START`=1 the state is ASSERT on the edge after that.
- From DONE, `start` pulse → all channels low on the same edge, flags cleared, and the release sequence repeats with identical timing.
- `NUM_CH`=4, `STAGGER`=0, `RST_CYCLES`=1 → all 4 channels and `running` rise together at E1.
